// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory interface widths, data-memory depth and
// the state encoding of the data-memory clear engine.
package cpu_pkg;

  localparam int MEM_ADDR_WIDTH = 11;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int DMEM_DEPTH     = 1024;

  typedef enum logic [0:0] {
    DM_IDLE  = 1'b0,
    DM_CLEAR = 1'b1
  } dmem_state_e;

  // Index width needed to address 'depth' words (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// 1W1R synchronous-read RAM with write-first bypass and a registered read
// port. The storage itself carries no reset so it maps onto block RAM; only
// the read register is reset. i_rd_zero forces a zero read result (used for
// out-of-range reads whose truncated index must not reach the array).
module dmem_array
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  input  logic              i_rd_zero,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              w_bypass;

  // A write landing on the address being read this cycle is returned directly.
  assign w_bypass = i_we && (i_waddr == i_raddr);

  // Storage write port.
  always_ff @(posedge Clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register: loads on a read strobe, otherwise holds its last value.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rdata <= {DATA_W{1'b0}};
    end else if (i_re) begin
      if (i_rd_zero) begin
        r_rdata <= {DATA_W{1'b0}};
      end else if (w_bypass) begin
        r_rdata <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_raddr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory-access stage. Fixed 1-cycle read
// latency, single physical write port shared (in priority order) by CPU
// writes, the sequential clear engine and the preload port. Out-of-range
// accesses are dropped/read as zero and raise a sticky error flag; CPU
// reads and writes are counted with saturating counters.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_WIDTH,
  parameter int DATA_W = MEM_DATA_WIDTH,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] Dmem_Waddr,
  input  logic [DATA_W-1:0] Dmem_Wdata,
  input  logic              Dmem_Wen,
  input  logic [ADDR_W-1:0] Dmem_Raddr,
  input  logic              Dmem_Ren,
  output logic [DATA_W-1:0] Dmem_Rdata,
  input  logic              Init_Valid_i,
  input  logic [ADDR_W-1:0] Init_Addr_i,
  input  logic [DATA_W-1:0] Init_Data_i,
  output logic              Init_Ready_o,
  input  logic              Clr_Start_i,
  output logic              Clr_Busy_o,
  output logic              Oob_Err_o,
  input  logic              Err_Clr_i,
  output logic [CNT_W-1:0]  Rd_Cnt_o,
  output logic [CNT_W-1:0]  Wr_Cnt_o
);

  localparam int                IDX_W     = idx_width(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  dmem_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic              r_oob_err;
  logic [CNT_W-1:0]  r_rd_cnt, r_wr_cnt;

  logic              w_wr_oob, w_rd_oob, w_init_oob;
  logic              w_init_ready, w_init_fire, w_oob_set;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  logic [DATA_W-1:0] w_wdata;

  // Range checks are done on the full address before it is truncated to an index.
  assign w_wr_oob   = {1'b0, Dmem_Waddr}  >= DEPTH_EXT;
  assign w_rd_oob   = {1'b0, Dmem_Raddr}  >= DEPTH_EXT;
  assign w_init_oob = {1'b0, Init_Addr_i} >= DEPTH_EXT;

  assign w_init_ready = (r_state == DM_IDLE) && !Dmem_Wen;
  assign w_init_fire  = Init_Valid_i && w_init_ready;
  assign w_oob_set    = (Dmem_Wen && w_wr_oob) || (Dmem_Ren && w_rd_oob) ||
                        (w_init_fire && w_init_oob);

  // Write-port arbitration: CPU write, then clear engine, then preload.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = {IDX_W{1'b0}};
    w_wdata = {DATA_W{1'b0}};
    if (Dmem_Wen) begin
      w_we    = !w_wr_oob;
      w_waddr = Dmem_Waddr[IDX_W-1:0];
      w_wdata = Dmem_Wdata;
    end else if (r_state == DM_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_ptr;
      w_wdata = {DATA_W{1'b0}};
    end else if (w_init_fire) begin
      w_we    = !w_init_oob;
      w_waddr = Init_Addr_i[IDX_W-1:0];
      w_wdata = Init_Data_i;
    end else begin
      w_we    = 1'b0;
    end
  end

  // Clear engine next state: walk every word once, stalling on CPU writes.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      DM_IDLE: begin
        if (Clr_Start_i) begin
          w_state_nxt = DM_CLEAR;
          w_ptr_nxt   = {IDX_W{1'b0}};
        end else begin
          w_state_nxt = DM_IDLE;
        end
      end
      DM_CLEAR: begin
        if (Dmem_Wen) begin
          w_ptr_nxt = r_ptr;
        end else if (r_ptr == LAST_IDX) begin
          w_state_nxt = DM_IDLE;
          w_ptr_nxt   = {IDX_W{1'b0}};
        end else begin
          w_ptr_nxt = r_ptr + IDX_ONE;
        end
      end
      default: begin
        w_state_nxt = DM_IDLE;
        w_ptr_nxt   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Clear engine state and pointer registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= DM_IDLE;
      r_ptr   <= {IDX_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Sticky out-of-range flag; a new violation beats a clear request.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_oob_err <= 1'b0;
    end else if (w_oob_set) begin
      r_oob_err <= 1'b1;
    end else if (Err_Clr_i) begin
      r_oob_err <= 1'b0;
    end
  end

  // Saturating CPU read/write access counters.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rd_cnt <= {CNT_W{1'b0}};
      r_wr_cnt <= {CNT_W{1'b0}};
    end else begin
      if (Dmem_Ren && (r_rd_cnt != CNT_MAX)) begin
        r_rd_cnt <= r_rd_cnt + CNT_ONE;
      end
      if (Dmem_Wen && (r_wr_cnt != CNT_MAX)) begin
        r_wr_cnt <= r_wr_cnt + CNT_ONE;
      end
    end
  end

  dmem_array #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_array (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_re      (Dmem_Ren),
    .i_raddr   (Dmem_Raddr[IDX_W-1:0]),
    .i_rd_zero (w_rd_oob),
    .o_rdata   (Dmem_Rdata)
  );

  assign Init_Ready_o = w_init_ready;
  assign Clr_Busy_o   = (r_state == DM_CLEAR);
  assign Oob_Err_o    = r_oob_err;
  assign Rd_Cnt_o     = r_rd_cnt;
  assign Wr_Cnt_o     = r_wr_cnt;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that services the DMEM command interface driven by the memory-access stage. It has one write port and one synchronous read port with a fixed 1-cycle read latency. The memory-access stage depends on this latency without any handshake, so the latency must never vary. It also provides:
- a ready/valid init (preload) port;
- a sequential hardware clear engine;
- sticky out-of-bounds error reporting;
- saturating access counters for performance monitoring.

Parameters:
ADDR_W, MEM_ADDR_WIDTH, word-address width of the DMEM interface
DATA_W, MEM_DATA_WIDTH, data word width
DEPTH, 1024, number of implemented words; must be <= 2**ADDR_W
CNT_W, 32, width of the access counters

Ports:
Clk  in  1  clock
Rst_n  in  1  asynchronous, active-low reset
Dmem_Waddr  in  ADDR_W  write word address
Dmem_Wdata  in  DATA_W  write data
Dmem_Wen  in  1  write strobe
Dmem_Raddr  in  ADDR_W  read word address
Dmem_Ren  in  1  read strobe
Dmem_Rdata  out  DATA_W  registered read data, valid the cycle after Dmem_Ren
Init_Valid_i  in  1  preload write valid
Init_Addr_i  in  ADDR_W  preload address
Init_Data_i  in  DATA_W  preload data
Init_Ready_o  out  1  preload port ready
Clr_Start_i  in  1  start a full-memory clear (pulse)
Clr_Busy_o  out  1  clear engine active
Oob_Err_o  out  1  sticky out-of-bounds access flag
Err_Clr_i  in  1  clear Oob_Err_o
Rd_Cnt_o  out  CNT_W  count of CPU reads
Wr_Cnt_o  out  CNT_W  count of CPU writes

Behaviour:
- Reset values:
  - Dmem_Rdata=0, Oob_Err_o=0, Rd_Cnt_o=0, Wr_Cnt_o=0, Clr_Busy_o=0.
  - FSM=DM_IDLE, clear pointer=0.
  - Init_Ready_o=1 once reset is released, provided Dmem_Wen=0.
  - Storage array is not reset.
- Read:
  - Dmem_Ren=1 at edge N with Raddr=A: Dmem_Rdata = mem[A] after edge N+1's preceding cycle, i.e. visible during cycle N+1.
  - Dmem_Ren=0: Dmem_Rdata holds its last value.
- Write: Dmem_Wen=1 writes mem[Waddr] <= Wdata at the clock edge.
- Read-during-write to the same address in the same cycle: write-first. Rdata returns the new Wdata.
- Out of bounds (address >= DEPTH):
  - Write is dropped; read returns 0.
  - Oob_Err_o is set the next cycle.
  - Flag stays set until Err_Clr_i. If a set and Err_Clr_i occur in the same cycle, the set wins.
- Write-port arbitration, single physical port, priority order: CPU write > clear engine > init port.
  - Init_Ready_o = (state==DM_IDLE) && !Dmem_Wen.
  - An init write occurs when Init_Valid_i && Init_Ready_o. Init writes to OOB addresses are dropped and set Oob_Err_o.
- Clear FSM:
  - DM_IDLE: Clr_Start_i -> DM_CLEAR, pointer=0.
  - DM_CLEAR: each cycle without a CPU write, writes 0 to mem[pointer] and increments the pointer. A cycle with a CPU write stalls the pointer.
  - After writing DEPTH-1 -> DM_IDLE.
  - Clr_Start_i while in DM_CLEAR is ignored.
  - Clr_Busy_o = (state==DM_CLEAR).
  - CPU reads are serviced normally during a clear.
  - A CPU write to an address >= pointer during a clear is later zeroed; this is a software responsibility.
  - Clear of DEPTH words takes DEPTH cycles plus the number of stall cycles.
- Counters:
  - Rd_Cnt_o increments on every Dmem_Ren; Wr_Cnt_o increments on every Dmem_Wen. Both count in-range and OOB accesses.
  - Both saturate at all-ones.
  - Init and clear writes are not counted.
- Reset mid-clear: FSM returns to DM_IDLE. Memory is left partially cleared and the clear is not resumed.
- Simultaneous Wen and Ren to different addresses are fully independent and complete in the same cycle.

Decomposition:
- cpu_pkg gains:
  - enum dmem_state_e {DM_IDLE, DM_CLEAR};
  - localparam DMEM_DEPTH.
  - MEM_ADDR_WIDTH and MEM_DATA_WIDTH are reused from cpu_pkg.
- One sub-module, dmem_array: 1W1R synchronous-read RAM, parameterized on depth and width, with write-first bypass and a registered read output. It must infer block RAM plus the bypass mux.
- dmem_responder keeps the arbitration, clear FSM, OOB logic and counters.

Test Plan:
- Write A=5, D=0xDEADBEEF; next cycle Ren A=5 -> Rdata=0xDEADBEEF exactly 1 cycle later; Rdata holds while Ren=0.
- Same cycle: Wen A=9 D=0x11 and Ren A=9 (old value 0x22) -> Rdata=0x11; Wr_Cnt_o=1, Rd_Cnt_o=1.
- Ren A=DEPTH (1024) -> Rdata=0 and Oob_Err_o=1 the next cycle; Err_Clr_i and a new OOB access in the same cycle -> flag stays 1; Err_Clr_i alone -> 0.
- Init_Valid_i=1 with Dmem_Wen=1 -> Init_Ready_o=0 and no init write; next cycle Wen=0 -> init write to A=3 D=0x77 completes; readback 0x77.
- Preload words 0..3 with nonzero data; Clr_Start_i; 2 CPU writes mid-clear -> Clr_Busy_o high for DEPTH+2 cycles; all reads return 0 afterwards.
- Assert Rst_n=0 while pointer=100 during a clear -> Clr_Busy_o=0 and all counters 0; words 0..99 read 0 and word 100+ keeps its preloaded value.
